// File: rtl/a_io_l3_in_serialize_a_m_axi_srl_fifo_ctrl.sv
// a_io_l3_in_serialize_a_m_axi_srl_fifo_ctrl: FWFT FIFO sequencer driving an SRL with a registered dout
module a_io_l3_in_serialize_a_m_axi_srl_fifo_ctrl #(
  parameter int DEPTH      = 63,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_LEVEL   = 56
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clk_en,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_srl_we,
  output logic                  o_srl_re,
  output logic [ADDR_WIDTH-1:0] o_srl_raddr,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full
);
  localparam int CW = ADDR_WIDTH + 1;
  logic [CW-1:0] r_mem_cnt;
  logic          r_out_valid;
  logic          w_push;
  logic          w_pop;
  always_comb begin
    o_s_ready     = r_mem_cnt != CW'(DEPTH - 1);
    o_m_valid     = r_out_valid;
    w_push        = i_clk_en & ~i_flush & i_s_valid & o_s_ready;
    w_pop         = i_clk_en & ~i_flush & r_out_valid & i_m_ready;
    o_srl_we      = w_push;
    o_srl_re      = i_clk_en & ~i_flush & (r_mem_cnt != '0) & (~r_out_valid | i_m_ready);
    // tap uses pre-update count: the SRL read samples contents before this cycle's shift
    o_srl_raddr   = (r_mem_cnt != '0) ? ADDR_WIDTH'(r_mem_cnt - CW'(1)) : '0;
    o_count       = r_mem_cnt + CW'(r_out_valid);
    o_full        = o_count == CW'(DEPTH);
    o_empty       = o_count == '0;
    o_almost_full = o_count >= CW'(AF_LEVEL);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (i_clk_en) begin
      r_mem_cnt   <= i_flush ? '0 : r_mem_cnt + CW'(w_push) - CW'(o_srl_re);
      r_out_valid <= ~i_flush & (o_srl_re | (r_out_valid & ~w_pop));
    end
  end
endmodule
